// File: rtl/change_dispenser_pkg.sv
// Shared types and defaults for the change dispenser and its coin picker.
package change_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam int NUM_DENOM_DEF = 4;
  localparam int AMOUNT_W_DEF  = 9;

  // Element 0 is the largest coin; the picker scans from index 0 upward.
  localparam logic [0:NUM_DENOM_DEF-1][AMOUNT_W_DEF-1:0] DENOM_VALS_DEF =
    {9'd100, 9'd25, 9'd10, 9'd5};

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational largest-first picker: lowest index whose value fits and has stock.
module coin_select
  import change_pkg::*;
#(
  parameter int AMOUNT_W  = AMOUNT_W_DEF,
  parameter int NUM_DENOM = NUM_DENOM_DEF,
  parameter int INV_W     = 8,
  parameter int IDX_W     = idx_w(NUM_DENOM)
) (
  input  logic [AMOUNT_W-1:0]                    rem,
  input  logic [NUM_DENOM-1:0][INV_W-1:0]        inv,
  input  logic [0:NUM_DENOM-1][AMOUNT_W-1:0]     vals,
  output logic                                   found,
  output logic [IDX_W-1:0]                       idx,
  output logic [NUM_DENOM-1:0]                   onehot
);

  // Walk from the smallest coin up so the last hit is the lowest index.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = NUM_DENOM - 1; i >= 0; i--) begin
      if (vals[i] <= rem && inv[i] != '0) begin
        found     = 1'b1;
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Sequential change dispenser: one coin per clock, greedy, with per-denomination inventory.
module change_dispenser
  import change_pkg::*;
#(
  parameter int AMOUNT_W  = AMOUNT_W_DEF,
  parameter int NUM_DENOM = NUM_DENOM_DEF,
  parameter int INV_W     = 8,
  parameter logic [0:NUM_DENOM-1][AMOUNT_W-1:0] DENOM_VALS = DENOM_VALS_DEF,
  localparam int IDX_W    = idx_w(NUM_DENOM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [AMOUNT_W-1:0]           amount,
  output logic                          busy,
  output logic                          done,
  output logic                          short,
  output logic [AMOUNT_W-1:0]           remainder,
  output logic [NUM_DENOM*INV_W-1:0]    counts,
  output logic                          coin_valid,
  output logic [NUM_DENOM-1:0]          coin_sel,
  input  logic                          inv_load,
  input  logic [IDX_W-1:0]              inv_idx,
  input  logic [INV_W-1:0]              inv_val,
  input  logic                          inv_add,
  output logic [NUM_DENOM*INV_W-1:0]    inv_level
);

  state_t                          state;
  logic [AMOUNT_W-1:0]             rem_q;
  logic [NUM_DENOM-1:0][INV_W-1:0] inv_q, inv_nxt, cnt_q;
  logic                            found;
  logic [IDX_W-1:0]                pick_idx;
  logic [NUM_DENOM-1:0]            pick_oh;
  logic                            issue;

  assign busy      = (state == SCAN);
  assign issue     = busy && found;
  assign counts    = cnt_q;
  assign inv_level = inv_q;

  coin_select #(
    .AMOUNT_W (AMOUNT_W),
    .NUM_DENOM(NUM_DENOM),
    .INV_W    (INV_W),
    .IDX_W    (IDX_W)
  ) u_sel (
    .rem   (rem_q),
    .inv   (inv_q),
    .vals  (DENOM_VALS),
    .found (found),
    .idx   (pick_idx),
    .onehot(pick_oh)
  );

  // Load beats add; an add colliding with this cycle's issue nets to zero.
  for (genvar i = 0; i < NUM_DENOM; i++) begin : g_inv
    logic hit, dec, load, add;
    assign hit  = (inv_idx == IDX_W'(i));
    assign dec  = issue && pick_oh[i];
    assign load = inv_load && !busy && hit;
    assign add  = inv_add && hit;
    assign inv_nxt[i] = load           ? inv_val :
                        (add && !dec)  ? ((inv_q[i] == '1) ? inv_q[i] : inv_q[i] + INV_W'(1)) :
                        (dec && !add)  ? inv_q[i] - INV_W'(1) :
                                         inv_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= '0;
    else        inv_q <= inv_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem_q      <= '0;
      cnt_q      <= '0;
      done       <= 1'b0;
      short      <= 1'b0;
      remainder  <= '0;
      coin_valid <= 1'b0;
      coin_sel   <= '0;
    end else begin
      done       <= 1'b0;
      coin_valid <= 1'b0;
      coin_sel   <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            rem_q <= amount;
            cnt_q <= '0;
            short <= 1'b0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (found) begin
            rem_q           <= rem_q - DENOM_VALS[pick_idx];
            cnt_q[pick_idx] <= cnt_q[pick_idx] + INV_W'(1);
            coin_valid      <= 1'b1;
            coin_sel        <= pick_oh;
          end else begin
            state     <= IDLE;
            done      <= 1'b1;
            remainder <= rem_q;
            short     <= (rem_q != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
